uart_core_param: RTL

Parametrised full-duplex UART core: a transmitter with a valid/ready byte interface and a mid-bit-sampling receiver, both timed from the system clock by a programmable clocks-per-bit divider. It replaces the fixed 8-bit, fixed-baud, ROM-fed transmitter/receiver pair with a reusable block. Data width, stop-bit count and parity are configurable. It sits between on-chip logic (byte producer/consumer) and the board-level serial pins.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_bit_timer.sv | 35 +++
 rtl/uart_core_param.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART core.
// The frame-length helper takes parity as an argument; the UART_PARITY_EN build option is applied in uart_core_param.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    function automatic int frame_len(input int data_bits, input int stop_bits, input bit parity_en);
        return 1 + data_bits + (parity_en ? 1 : 0) + stop_bits;
    endfunction

    function automatic int timer_width(input int clk_div);
        return $clog2(clk_div);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter for UART bit timing; tc is high while the count sits at zero,
// so loading value V produces the next terminal count V+1 cycles later.
module uart_bit_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/uart_core_param.sv
// Full-duplex UART: valid/ready transmitter and mid-bit-sampling receiver.
// Define UART_PARITY_EN to add a parity bit to both directions.
//
// state  | meaning
// IDLE   | TX: waiting for tx_valid; RX: waiting for falling edge on synced rx
// START  | start bit; RX re-checks the line at mid-bit to reject glitches
// DATA   | DATA_BITS payload bits, LSB first
// PARITY | parity bit (only with UART_PARITY_EN)
// STOP   | stop bit(s); RX reports the frame, then waits for the line high
module uart_core_param
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 5208,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);

    localparam int TW = timer_width(CLK_DIV);
    localparam int CW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] BIT_RELOAD  = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] HALF_RELOAD = TW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] LAST_BIT    = CW'(DATA_BITS - 1);

    // ---------------- transmitter ----------------
    uart_state_e          tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [CW-1:0]        tx_bit_q, tx_bit_d;
    logic                 tx_stop_q, tx_stop_d;
    logic                 tx_q, tx_d;
    logic                 tx_load;
    logic                 tx_tc;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    uart_bit_timer #(.WIDTH(TW)) u_tx_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tx_load),
        .load_val (BIT_RELOAD),
        .tc       (tx_tc)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_stop_d  = tx_stop_q;
        tx_d       = tx_q;
        tx_load    = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            IDLE: begin
                if (tx_valid) begin
                    tx_state_d = START;
                    tx_shift_d = tx_data;
                    tx_bit_d   = '0;
                    tx_stop_d  = 1'b0;
                    tx_d       = 1'b0;
                    tx_load    = 1'b1;
`ifdef UART_PARITY_EN
                    tx_par_d   = (^tx_data) ^ (PARITY_ODD != 0);
`endif
                end
            end
            START: begin
                if (tx_tc) begin
                    tx_state_d = DATA;
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                    tx_load    = 1'b1;
                end
            end
            DATA: begin
                if (tx_tc) begin
                    tx_load = 1'b1;
                    if (tx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        tx_state_d = PARITY;
                        tx_d       = tx_par_q;
`else
                        tx_state_d = STOP;
                        tx_d       = 1'b1;
`endif
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (tx_tc) begin
                    tx_state_d = STOP;
                    tx_d       = 1'b1;
                    tx_load    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tx_tc) begin
                    if (STOP_BITS == 2 && !tx_stop_q) begin
                        tx_stop_d = 1'b1;
                        tx_load   = 1'b1;
                    end else begin
                        tx_state_d = IDLE;
                    end
                end
            end
            default: begin
                tx_state_d = IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= IDLE;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_stop_q  <= tx_stop_d;
            tx_q       <= tx_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    assign tx_ready = (tx_state_q == IDLE);
    assign tx       = tx_q;

    // ---------------- receiver ----------------
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    uart_state_e          rx_state_q, rx_state_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [CW-1:0]        rx_bit_q, rx_bit_d;
    logic                 rx_wait_q, rx_wait_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_load;
    logic [TW-1:0]        rx_load_val;
    logic                 rx_tc;
`ifdef UART_PARITY_EN
    logic                 rx_par_q, rx_par_d;
    logic                 rx_perr_q, rx_perr_d;
`endif

    uart_bit_timer #(.WIDTH(TW)) u_rx_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (rx_load),
        .load_val (rx_load_val),
        .tc       (rx_tc)
    );

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_shift_d  = rx_shift_q;
        rx_bit_d    = rx_bit_q;
        rx_wait_d   = rx_wait_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_ferr_d   = rx_ferr_q;
        rx_load     = 1'b0;
        rx_load_val = BIT_RELOAD;
`ifdef UART_PARITY_EN
        rx_par_d    = rx_par_q;
        rx_perr_d   = rx_perr_q;
`endif
        case (rx_state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d  = START;
                    rx_load     = 1'b1;
                    rx_load_val = HALF_RELOAD;
                end
            end
            START: begin
                if (rx_tc) begin
                    if (rx_s2_q) begin
                        rx_state_d = IDLE;
                    end else begin
                        rx_state_d = DATA;
                        rx_bit_d   = '0;
                        rx_load    = 1'b1;
                    end
                end
            end
            DATA: begin
                if (rx_tc) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_load    = 1'b1;
                    if (rx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        rx_state_d = PARITY;
`else
                        rx_state_d = STOP;
`endif
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (rx_tc) begin
                    rx_par_d   = rx_s2_q;
                    rx_state_d = STOP;
                    rx_load    = 1'b1;
                end
            end
`endif
            STOP: begin
                // A low stop bit parks here until the line recovers, so a break cannot retrigger.
                if (rx_wait_q) begin
                    if (rx_s2_q) begin
                        rx_wait_d  = 1'b0;
                        rx_state_d = IDLE;
                    end
                end else if (rx_tc) begin
                    rx_data_d  = rx_shift_q;
                    rx_ferr_d  = !rx_s2_q;
                    rx_valid_d = 1'b1;
`ifdef UART_PARITY_EN
                    rx_perr_d  = ((^rx_shift_q) ^ (PARITY_ODD != 0)) != rx_par_q;
`endif
                    if (rx_s2_q) begin
                        rx_state_d = IDLE;
                    end else begin
                        rx_wait_d = 1'b1;
                    end
                end
            end
            default: begin
                rx_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= IDLE;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            rx_wait_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_q   <= 1'b0;
            rx_perr_q  <= 1'b0;
`endif
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            rx_wait_q  <= rx_wait_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
`ifdef UART_PARITY_EN
            rx_par_q   <= rx_par_d;
            rx_perr_q  <= rx_perr_d;
`endif
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_ferr_q;
`ifdef UART_PARITY_EN
    assign rx_parity_err = rx_perr_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule
